// File: rtl/mole_cmd_reader.sv
// Whack-a-mole command channel: snoops regfile writes to the command register, lights one lamp
// for a timed window and reports hit (with reaction time), miss, or a bad lamp index.
module mole_cmd_reader #(
  parameter int unsigned CMD_REG   = 29,
  parameter int unsigned NUM_LAMPS = 6,
  parameter int unsigned TICK_DIV  = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rf_we,
  input  logic [4:0]           rf_rd,
  input  logic [31:0]          rf_data,
  input  logic [NUM_LAMPS-1:0] btn_n,
  output logic [NUM_LAMPS-1:0] lamp,
  output logic                 busy,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 err_pulse,
  output logic [15:0]          reaction
);

  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [4:0]    CMD_ADDR = 5'(CMD_REG);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LIT    = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          prescale_q, prescale_d;
  logic [15:0]            elapsed_q, elapsed_d;
  logic [15:0]            dur_q, dur_d;
  logic [NUM_LAMPS-1:0]   lamp_d;
  logic                   busy_d, hit_d, miss_d, err_d;
  logic [15:0]            reaction_d;
  logic [NUM_LAMPS-1:0]   btn_s1, btn_s2, btn_s3;

  logic                   cmd_c, start_c, abort_c, idx_ok_c;
  logic [2:0]             idx_c;
  logic [NUM_LAMPS-1:0]   press_c;
  logic                   hit_c, wrap_c, expire_c;
  logic                   unused_bits;

  // Command decode; ABORT overrides START when both are set
  assign cmd_c    = rf_we && (rf_rd == CMD_ADDR);
  assign start_c  = cmd_c && rf_data[31] && !rf_data[30];
  assign abort_c  = cmd_c && rf_data[30];
  assign idx_c    = rf_data[2:0];
  assign idx_ok_c = 32'(idx_c) < NUM_LAMPS;
  assign unused_bits = ^{rf_data[29:24], rf_data[7:3]};

  // Falling edge on the synchronised button; lamp is one-hot so it selects the watched button
  assign press_c  = btn_s3 & ~btn_s2;
  assign hit_c    = |(press_c & lamp);
  assign wrap_c   = (prescale_q == PS_LAST);
  assign expire_c = (dur_q == 16'd0) ||
                    (wrap_c && ((17'(elapsed_q) + 17'd1) >= 17'(dur_q)));

  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    elapsed_d  = elapsed_q;
    dur_d      = dur_q;
    lamp_d     = lamp;
    busy_d     = busy;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    err_d      = 1'b0;
    reaction_d = reaction;

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          if (idx_ok_c) begin
            state_d    = S_LIT;
            dur_d      = rf_data[23:8];
            prescale_d = '0;
            elapsed_d  = '0;
            lamp_d     = NUM_LAMPS'(1) << idx_c;
            busy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LIT: begin
        prescale_d = wrap_c ? '0 : prescale_q + PW'(1);
        if (wrap_c && (elapsed_q != 16'hFFFF)) begin
          elapsed_d = elapsed_q + 16'd1;
        end
        // Hit beats expiry, expiry beats abort
        if (hit_c) begin
          state_d    = S_RESULT;
          hit_d      = 1'b1;
          reaction_d = elapsed_q;
          lamp_d     = '0;
          busy_d     = 1'b0;
        end else if (expire_c) begin
          state_d = S_RESULT;
          miss_d  = 1'b1;
          lamp_d  = '0;
          busy_d  = 1'b0;
        end else if (abort_c) begin
          state_d = S_IDLE;
          lamp_d  = '0;
          busy_d  = 1'b0;
        end
      end

      S_RESULT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        lamp_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      prescale_q <= '0;
      elapsed_q  <= '0;
      dur_q      <= '0;
      lamp       <= '0;
      busy       <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      reaction   <= '0;
      btn_s1     <= '1;
      btn_s2     <= '1;
      btn_s3     <= '1;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      elapsed_q  <= elapsed_d;
      dur_q      <= dur_d;
      lamp       <= lamp_d;
      busy       <= busy_d;
      hit_pulse  <= hit_d;
      miss_pulse <= miss_d;
      err_pulse  <= err_d;
      reaction   <= reaction_d;
      btn_s1     <= btn_n;
      btn_s2     <= btn_s1;
      btn_s3     <= btn_s2;
    end
  end

endmodule

// File: tb/tb_mole_cmd_reader.sv
// Bench for mole_cmd_reader: constant vector table, directed multi-cycle sequences and
// random traffic, all compared against a window/tick reference model.
module tb_mole_cmd_reader;

  localparam int unsigned NL = 6;
  localparam int unsigned TD = 4;
  localparam int unsigned CR = 29;

  logic          clk = 1'b0;
  logic          reset;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_data;
  logic [NL-1:0] btn_n;
  logic [NL-1:0] lamp;
  logic          busy, hit_pulse, miss_pulse, err_pulse;
  logic [15:0]   reaction;

  always #5 clk = ~clk;

  mole_cmd_reader #(.CMD_REG(CR), .NUM_LAMPS(NL), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_data    (rf_data),
    .btn_n      (btn_n),
    .lamp       (lamp),
    .busy       (busy),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .err_pulse  (err_pulse),
    .reaction   (reaction)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a lamp window of max(1, dur*TD) cycles counted from entry
  bit            m_active, m_result;
  int            m_k, m_dur, m_idx;
  logic [NL-1:0] h1, h2, h3;
  logic [NL-1:0] e_lamp;
  logic          e_busy, e_hit, e_miss, e_err;
  logic [15:0]   e_react;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NL-1:0] press;
    bit cmd;
    int k, win;
    e_hit = 1'b0; e_miss = 1'b0; e_err = 1'b0;
    if (reset) begin
      m_active = 0; m_result = 0; m_k = 0;
      h1 = '1; h2 = '1; h3 = '1;
      e_react = '0;
    end else begin
      press = h3 & ~h2;
      h3 = h2; h2 = h1; h1 = btn_n;
      cmd = rf_we && (rf_rd == 5'(CR));
      if (m_result) begin
        m_result = 0;
      end else if (m_active) begin
        k   = m_k + 1;
        win = (m_dur == 0) ? 1 : m_dur * int'(TD);
        if (press[m_idx]) begin
          e_hit = 1'b1;
          e_react = ((k - 1) / int'(TD) > 65535) ? 16'hFFFF : 16'((k - 1) / int'(TD));
          m_active = 0; m_result = 1;
        end else if (k >= win) begin
          e_miss = 1'b1;
          m_active = 0; m_result = 1;
        end else if (cmd && rf_data[30]) begin
          m_active = 0;
        end else begin
          m_k = k;
        end
      end else if (cmd && rf_data[31] && !rf_data[30]) begin
        if (int'(rf_data[2:0]) < int'(NL)) begin
          m_active = 1; m_k = 0;
          m_idx = int'(rf_data[2:0]);
          m_dur = int'(rf_data[23:8]);
        end else begin
          e_err = 1'b1;
        end
      end
    end
    e_lamp = m_active ? (NL'(1) << m_idx) : '0;
    e_busy = m_active;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("lamp",     32'(lamp),       32'(e_lamp));
    check("busy",     32'(busy),       32'(e_busy));
    check("hit",      32'(hit_pulse),  32'(e_hit));
    check("miss",     32'(miss_pulse), 32'(e_miss));
    check("err",      32'(err_pulse),  32'(e_err));
    check("reaction", 32'(reaction),   32'(e_react));
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] data);
    rf_we = 1'b1; rf_rd = rd; rf_data = data;
    cycle();
    rf_we = 1'b0; rf_rd = 5'd0; rf_data = 32'd0;
  endtask

  task automatic run_until(input bit want_hit, input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(want_hit ? hit_pulse : miss_pulse) && n < budget);
  endtask

  typedef struct {
    logic          rst;
    logic          we;
    logic [4:0]    rd;
    logic [31:0]   data;
    logic [NL-1:0] lamp;
    logic          busy, hit, miss, err;
  } vec_t;

  vec_t vt[13];

  initial begin
    int n;
    reset = 1'b1; rf_we = 1'b0; rf_rd = 5'd0; rf_data = 32'd0; btn_n = '1;
    m_active = 0; m_result = 0; m_k = 0; m_dur = 0; m_idx = 0;
    h1 = '1; h2 = '1; h3 = '1;
    e_lamp = '0; e_busy = 0; e_hit = 0; e_miss = 0; e_err = 0; e_react = '0;

    vt[0]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 5'd28, 32'h8000_0302, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 5'd29, 32'h8000_0107, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 5'd0,  32'h0000_0000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 5'd29, 32'h4000_0000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 5'd29, 32'h0000_0302, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 5'd29, 32'h8000_0000, 6'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 5'd0,  32'h0000_0000, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 5'd0,  32'h0000_0000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 5'd29, 32'hC000_0302, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 5'd29, 32'h8000_0105, 6'h20, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 5'd29, 32'h4000_0000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 5'd0,  32'h0000_0000, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      reset = vt[i].rst; rf_we = vt[i].we; rf_rd = vt[i].rd; rf_data = vt[i].data;
      cycle();
      check($sformatf("tbl%0d_lamp", i), 32'(lamp),       32'(vt[i].lamp));
      check($sformatf("tbl%0d_busy", i), 32'(busy),       32'(vt[i].busy));
      check($sformatf("tbl%0d_hit", i),  32'(hit_pulse),  32'(vt[i].hit));
      check($sformatf("tbl%0d_miss", i), 32'(miss_pulse), 32'(vt[i].miss));
      check($sformatf("tbl%0d_err", i),  32'(err_pulse),  32'(vt[i].err));
      check($sformatf("tbl%0d_react", i), 32'(reaction),  32'd0);
    end
    reset = 1'b0; rf_we = 1'b0; rf_rd = 5'd0; rf_data = 32'd0;

    // Untouched window: miss 12 cycles after entry
    wr(5'd29, 32'h8000_0302);
    check("t1_lamp", 32'(lamp), 32'h04);
    check("t1_busy", 32'(busy), 32'd1);
    run_until(1'b0, 40, n);
    check("t1_miss_latency", 32'(n), 32'd12);
    check("t1_lamp_off", 32'(lamp), 32'd0);
    cycle();

    // Press in third tick: hit 3 cycles after pin edge, reaction 2
    wr(5'd29, 32'h8000_0302);
    repeat (6) cycle();
    btn_n[2] = 1'b0;
    run_until(1'b1, 10, n);
    check("t2_hit_latency", 32'(n), 32'd3);
    check("t2_reaction", 32'(reaction), 32'd2);
    check("t2_lamp_off", 32'(lamp), 32'd0);
    btn_n = '1;
    repeat (4) cycle();

    // Wrong button ignored, then abort during a fresh window
    wr(5'd29, 32'h8000_0A01);
    repeat (3) cycle();
    btn_n[4] = 1'b0;
    repeat (3) cycle();
    btn_n[4] = 1'b1;
    run_until(1'b0, 60, n);
    check("t3_miss_at", 32'(n + 6), 32'd40);
    check("t3_reaction_hold", 32'(reaction), 32'd2);
    cycle();
    wr(5'd29, 32'h8000_0A01);
    repeat (5) cycle();
    wr(5'd29, 32'h4000_0000);
    check("t3_abort_lamp", 32'(lamp), 32'd0);
    check("t3_abort_busy", 32'(busy), 32'd0);
    check("t3_abort_nopulse", 32'({hit_pulse, miss_pulse, err_pulse}), 32'd0);
    cycle();

    // Bad index, and a write to a different register
    wr(5'd29, 32'h8000_0107);
    check("t4_err", 32'(err_pulse), 32'd1);
    check("t4_lamp", 32'(lamp), 32'd0);
    cycle();
    wr(5'd28, 32'h8000_0302);
    check("t4_other_reg", 32'({lamp, busy, err_pulse}), 32'd0);

    // Press landing on the final tick wins over expiry; second START ignored
    wr(5'd29, 32'h8000_0203);
    wr(5'd29, 32'h8000_0305);
    check("t5_restart_ignored", 32'(lamp), 32'h08);
    repeat (4) cycle();
    btn_n[3] = 1'b0;
    run_until(1'b1, 10, n);
    check("t5_hit_latency", 32'(n), 32'd3);
    check("t5_no_miss", 32'(miss_pulse), 32'd0);
    check("t5_reaction", 32'(reaction), 32'd1);
    btn_n = '1;
    repeat (4) cycle();

    // Reset mid-window, then a normal command
    wr(5'd29, 32'h8000_0500);
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    check("t6_rst_lamp", 32'(lamp), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_react", 32'(reaction), 32'd0);
    reset = 1'b0;
    wr(5'd29, 32'h8000_0104);
    check("t6_lamp", 32'(lamp), 32'h10);
    run_until(1'b0, 10, n);
    check("t6_miss_latency", 32'(n), 32'd4);
    cycle();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [2:0]  kind;
      logic [15:0] dur;
      kind    = 3'($urandom_range(0, 7));
      dur     = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40))
                                            : 16'($urandom_range(0, 6));
      reset   = ($urandom_range(0, 799) == 0);
      rf_we   = ($urandom_range(0, 5) == 0);
      rf_rd   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(CR);
      rf_data = {(kind <= 3'd4) || (kind == 3'd6), (kind == 3'd5) || (kind == 3'd6),
                 6'($urandom), dur, 5'($urandom),
                 ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7))
                                             : 3'($urandom_range(0, 5))};
      for (int b = 0; b < int'(NL); b++) begin
        if ($urandom_range(0, 5) == 0) btn_n[b] = ~btn_n[b];
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
